// File: rtl/ifmap_stream_pkg.sv
// Shared types and constants for the IFMap stream writer and its output queue.
package ifmap_stream_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned EOR_BIT    = DATA_WIDTH;
  localparam int unsigned EOM_BIT    = DATA_WIDTH + 1;

  typedef struct packed {
    logic                  eom;
    logic                  eor;
    logic [DATA_WIDTH-1:0] pix;
  } fifo_word_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

endpackage

// File: rtl/stream_out_queue.sv
// Depth-entry circular queue with same-cycle enqueue and dequeue; head is registered storage.
module stream_out_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 18,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enq_i,
  input  logic [Width-1:0] enq_data_i,
  input  logic            deq_i,
  output logic [Width-1:0] head_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, do_enq, do_deq;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full     = (count_q == CntW'(Depth));
    do_deq   = deq_i && (count_q != '0);
    // A full queue still accepts a write when the head leaves in the same cycle.
    do_enq   = enq_i && (!full || do_deq);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_enq) begin
      mem_d[wr_ptr_q] = enq_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_deq) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CntW'(do_enq) - CntW'(do_deq);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifmap_stream_writer.sv
// Streams a row-major feature map from memory into the PE IFMap FIFO with row/map end tags.
// Optional ZERO_PAD_EN adds a 3-bit pad port framing each row with zero words.
module ifmap_stream_writer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_SIZE   = 8,
  parameter int unsigned Q_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_SIZE-1:0]   row_len,
  input  logic [LEN_SIZE-1:0]   row_count,
`ifdef ZERO_PAD_EN
  input  logic [2:0]            pad,
`endif
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  fifo_ready,
  output logic                  fifo_wen,
  output logic [DATA_WIDTH+1:0] fifo_din,
  output logic                  busy,
  output logic                  done
);

  import ifmap_stream_pkg::*;

  localparam int unsigned FW   = DATA_WIDTH + 2;
  localparam int unsigned CntW = $clog2(Q_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;
  localparam int unsigned ColW = LEN_SIZE + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_SIZE-1:0]   row_len_q, row_len_d, row_count_q, row_count_d, row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic                  pend_q, pend_d, pend_pad_q, pend_pad_d;
  logic                  pend_eor_q, pend_eor_d, pend_eom_q, pend_eom_d;
  logic [2:0]            pad_val;

  logic [ColW-1:0]       lead_end, pix_end, col_last;
  logic                  slot_pix, slot_eor, slot_eom;
  logic [OccW-1:0]       occ;
  logic                  can_issue, issue;

  logic [CntW-1:0]       q_count;
  logic                  q_empty;
  logic [FW-1:0]         q_head;
  logic [DATA_WIDTH-1:0] pix_in;

`ifdef ZERO_PAD_EN
  logic [2:0] pad_q, pad_d;
  assign pad_val = pad_q;
`else
  assign pad_val = 3'd0;
`endif

  // Column runs over the padded row: [0, pad) lead pad, then pixels, then trailing pad.
  always_comb begin
    lead_end  = ColW'(pad_val);
    pix_end   = lead_end + ColW'(row_len_q);
    col_last  = pix_end + ColW'(pad_val) - ColW'(1);
    slot_pix  = (col_q >= lead_end) && (col_q < pix_end);
    slot_eor  = (col_q == col_last);
    slot_eom  = slot_eor && (row_q == row_count_q - LEN_SIZE'(1));
    // Slots committed after this cycle; a head leaving now frees its slot immediately.
    occ       = OccW'(q_count) + OccW'(pend_q) - OccW'(fifo_wen);
    can_issue = (occ < OccW'(Q_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_len_d   = row_len_q;
    row_count_d = row_count_q;
    row_d       = row_q;
    col_d       = col_q;
    issue       = 1'b0;
`ifdef ZERO_PAD_EN
    pad_d       = pad_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          row_len_d   = row_len;
          row_count_d = row_count;
          row_d       = '0;
          col_d       = '0;
`ifdef ZERO_PAD_EN
          pad_d       = pad;
`endif
          state_d     = ((row_len == '0) || (row_count == '0)) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (can_issue) begin
          issue = 1'b1;
          if (slot_pix) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
          if (slot_eor) begin
            col_d = '0;
            row_d = row_q + LEN_SIZE'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end
          if (slot_eom) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (occ == '0) begin
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pend_d     = issue;
    pend_pad_d = issue && !slot_pix;
    pend_eor_d = issue && slot_eor;
    pend_eom_d = issue && slot_eom;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      row_len_q   <= '0;
      row_count_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pend_q      <= 1'b0;
      pend_pad_q  <= 1'b0;
      pend_eor_q  <= 1'b0;
      pend_eom_q  <= 1'b0;
`ifdef ZERO_PAD_EN
      pad_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_len_q   <= row_len_d;
      row_count_q <= row_count_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pend_q      <= pend_d;
      pend_pad_q  <= pend_pad_d;
      pend_eor_q  <= pend_eor_d;
      pend_eom_q  <= pend_eom_d;
`ifdef ZERO_PAD_EN
      pad_q       <= pad_d;
`endif
    end
  end

  assign pix_in = pend_pad_q ? '0 : mem_rdata;

  stream_out_queue #(
    .Depth (Q_DEPTH),
    .Width (FW)
  ) u_queue (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .enq_i      (pend_q),
    .enq_data_i ({pend_eom_q, pend_eor_q, pix_in}),
    .deq_i      (fifo_wen),
    .head_o     (q_head),
    .empty_o    (q_empty),
    .count_o    (q_count)
  );

  assign mem_ren  = issue && slot_pix;
  assign mem_addr = addr_q;
  assign fifo_wen = !q_empty && fifo_ready;
  assign fifo_din = q_empty ? '0 : q_head;
  assign busy     = (state_q == FETCH) || (state_q == DRAIN);
  assign done     = (state_q == FINISH);

endmodule
